sound_event_seq: RTL and testbench

Sequencer that turns single-cycle game event pulses into the timed `win`/`die` request levels consumed by the speaker tone generator. It sits between the game-logic FSM and the tone block, and drives the producing end of the `win`/`die` interface.
- Win: one continuous tone request of fixed length.
- Die: a pattern of repeated beeps.
- Also provides `busy` and a completion pulse back to game logic.

---
 rtl/sound_event_seq_pkg.sv | 23 ++
 rtl/sound_event_seq_duration_timer.sv | 31 +++
 rtl/sound_event_seq.sv | 122 ++++++++++++
 tb/tb_sound_event_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sound_event_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sound_event_seq_pkg : state encoding and default sound durations   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sound_event_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WIN_ON  = 2'd1,
    S_DIE_ON  = 2'd2,
    S_DIE_OFF = 2'd3
  } state_t;

  // Defaults assume a 50 MHz clock, matching the tone generator.
  localparam int c_WIN_CYCLES_DEFAULT      = 25_000_000;
  localparam int c_BEEP_ON_CYCLES_DEFAULT  = 5_000_000;
  localparam int c_BEEP_OFF_CYCLES_DEFAULT = 5_000_000;
  localparam int c_DIE_BEEPS_DEFAULT       = 3;
  localparam int c_CNT_W_DEFAULT           = 25;

endpackage
`default_nettype wire

// File: rtl/sound_event_seq_duration_timer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | duration_timer : free counter with synchronous clear, flags limit-1|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module duration_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expire = (r_cnt == (limit - CNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/sound_event_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sound_event_seq : turns win/die event pulses into timed tone levels|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sound_event_seq
  import sound_event_seq_pkg::*;
#(
  parameter int WIN_CYCLES      = c_WIN_CYCLES_DEFAULT,
  parameter int BEEP_ON_CYCLES  = c_BEEP_ON_CYCLES_DEFAULT,
  parameter int BEEP_OFF_CYCLES = c_BEEP_OFF_CYCLES_DEFAULT,
  parameter int DIE_BEEPS       = c_DIE_BEEPS_DEFAULT,
  parameter int CNT_W           = c_CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic win_evt,
  input  logic die_evt,
  input  logic mute,
  output logic win,
  output logic die,
  output logic busy,
  output logic done
);

  localparam int c_BEEP_W = $clog2(DIE_BEEPS + 1);

  state_t              r_state;
  logic [c_BEEP_W-1:0] r_beeps;
  logic                r_done;
  logic                w_clear;
  logic                w_expire;
  logic [CNT_W-1:0]    w_limit;

  always_comb begin
    w_limit = CNT_W'(1);
    case (r_state)
      S_WIN_ON:  w_limit = CNT_W'(WIN_CYCLES);
      S_DIE_ON:  w_limit = CNT_W'(BEEP_ON_CYCLES);
      S_DIE_OFF: w_limit = CNT_W'(BEEP_OFF_CYCLES);
      default:   w_limit = CNT_W'(1);
    endcase
  end

  // The timer restarts on every state change or win retrigger, and sits at 0 in IDLE.
  always_comb begin
    w_clear = 1'b1;
    case (r_state)
      S_WIN_ON:  w_clear = die_evt | win_evt | w_expire;
      S_DIE_ON:  w_clear = w_expire;
      S_DIE_OFF: w_clear = w_expire;
      default:   w_clear = 1'b1;
    endcase
  end

  duration_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_clear),
    .limit  (w_limit),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beeps <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (die_evt) begin
            r_state <= S_DIE_ON;
            r_beeps <= c_BEEP_W'(1);
          end else if (win_evt) begin
            r_state <= S_WIN_ON;
          end
        end
        S_WIN_ON: begin
          if (die_evt) begin
            r_state <= S_DIE_ON;
            r_beeps <= c_BEEP_W'(1);
          end else if (!win_evt && w_expire) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_DIE_ON: begin
          if (w_expire) begin
            if (r_beeps == c_BEEP_W'(DIE_BEEPS)) begin
              r_state <= S_IDLE;
              r_beeps <= '0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DIE_OFF;
            end
          end
        end
        S_DIE_OFF: begin
          if (w_expire) begin
            r_state <= S_DIE_ON;
            r_beeps <= r_beeps + c_BEEP_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_beeps <= '0;
        end
      endcase
    end
  end

  assign win  = (r_state == S_WIN_ON) & ~mute;
  assign die  = (r_state == S_DIE_ON) & ~mute;
  assign busy = (r_state != S_IDLE);
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sound_event_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sound_event_seq : directed + random check against a timeline model|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sound_event_seq;

  localparam int c_WIN   = 8;
  localparam int c_ON    = 3;
  localparam int c_OFF   = 2;
  localparam int c_BEEPS = 3;
  localparam int c_DIE_TOTAL = c_BEEPS * c_ON + (c_BEEPS - 1) * c_OFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic win_evt = 1'b0;
  logic die_evt = 1'b0;
  logic mute = 1'b0;
  logic win, die, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which sound is playing and how many cycles of it have elapsed.
  int   m_mode = 0;  // 0 silent, 1 win, 2 die
  int   m_t    = 0;
  logic m_done = 1'b0;

  sound_event_seq #(
    .WIN_CYCLES      (c_WIN),
    .BEEP_ON_CYCLES  (c_ON),
    .BEEP_OFF_CYCLES (c_OFF),
    .DIE_BEEPS       (c_BEEPS),
    .CNT_W           (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .win_evt (win_evt),
    .die_evt (die_evt),
    .mute    (mute),
    .win     (win),
    .die     (die),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic e_win, e_die;
    e_win = (m_mode == 1) && !mute;
    e_die = (m_mode == 2) && ((m_t % (c_ON + c_OFF)) < c_ON) && !mute;
    chk("win",  win,  e_win);
    chk("die",  die,  e_die);
    chk("busy", busy, logic'(m_mode != 0));
    chk("done", done, m_done);
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_t    = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic d);
    m_done = 1'b0;
    case (m_mode)
      0: begin
        if (d) begin m_mode = 2; m_t = 0; end
        else if (w) begin m_mode = 1; m_t = 0; end
      end
      1: begin
        if (d) begin m_mode = 2; m_t = 0; end
        else if (w) m_t = 0;
        else if (m_t == c_WIN - 1) begin m_mode = 0; m_t = 0; m_done = 1'b1; end
        else m_t++;
      end
      default: begin
        if (m_t == c_DIE_TOTAL - 1) begin m_mode = 0; m_t = 0; m_done = 1'b1; end
        else m_t++;
      end
    endcase
  endtask

  // One clock cycle: drive inputs, check the current cycle, then advance the model.
  task automatic cyc(input logic w, input logic d, input logic m);
    @(negedge clk);
    win_evt = w;
    die_evt = d;
    mute    = m;
    #1;
    check_outputs();
    @(posedge clk);
    model_step(w, d);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Outputs during reset
    repeat (2) @(negedge clk);
    chk("rst_win",  win,  1'b0);
    chk("rst_die",  die,  1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    model_reset();

    // Plain win, then plain die
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(10);
    cyc(1'b0, 1'b1, 1'b0);
    idle_cycles(15);

    // Simultaneous events with a repeated die_evt at cycle 2
    cyc(1'b1, 1'b1, 1'b0);
    idle_cycles(1);
    cyc(1'b0, 1'b1, 1'b0);
    idle_cycles(13);

    // Preempt at cycle 4, retrigger at cycle 5
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(3);
    cyc(1'b0, 1'b1, 1'b0);
    idle_cycles(16);
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(4);
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(10);

    // Mute during cycles 3-5 of a win
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(2);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    idle_cycles(6);

    // Event in the done cycle, and a retrigger on the final win cycle
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(8);
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(7);
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(10);

    // Asynchronous reset in cycle 4 of a win
    cyc(1'b1, 1'b0, 1'b0);
    idle_cycles(3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_win",  win,  1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(12);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(logic'($urandom_range(0, 11) == 0),
          logic'($urandom_range(0, 24) == 0),
          logic'($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
